// File: rtl/cim_pkg.sv
// Shared CiM datapath constants and helpers.
// Used by the read-out pipeline and the occupancy counters.
package cim_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  localparam int POP_MAX = 64;
  localparam int POP_W   = $clog2(POP_MAX + 1);

  function automatic logic [POP_W-1:0] popcount(
    input logic [POP_MAX-1:0] bits
  );
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + POP_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline stage: valid bit plus data word.
// Flush clears valid only; data loads only with a valid source.
module pipe_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (en_i) begin
      valid_o <= src_valid_i;
      if (src_valid_i) begin
        data_o <= src_data_i;
      end
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage register chain with valid/ready handshake,
// bubble collapsing and synchronous flush.
module pipe_chain
  import cim_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;

  // A stage may load if it is empty or its successor moves on.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic             sv;
    logic [WIDTH-1:0] sd;

    if (k == 0) begin : g_head
      assign sv = in_valid_i & ~flush_i;
      assign sd = in_data_i;
    end else begin : g_body
      assign sv = v[k-1];
      assign sd = d[k-1];
    end

    pipe_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .flush_i    (flush_i),
      .en_i       (rdy[k]),
      .src_valid_i(sv),
      .src_data_i (sd),
      .valid_o    (v[k]),
      .data_o     (d[k])
    );
  end

  assign in_ready_o  = rdy[0] & ~flush_i;
  assign out_valid_o = v[DEPTH-1] & ~flush_i;
  assign out_data_o  = d[DEPTH-1];
  assign count_o     = CNT_W'(popcount(POP_MAX'(v)));

endmodule
